// File: rtl/rf_pkg.sv
// Shared types and width helpers for the RF transmit packetizer slice.
package rf_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    SEND
  } state_e;

  function automatic int addrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rf_sync_fifo.sv
// Single-clock FIFO with asynchronous (fall-through) read and occupancy count.
module rf_sync_fifo
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 512,
  localparam int AW = addrWidth(FIFO_DEPTH),
  localparam int CW = cntWidth(FIFO_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CW-1:0]         count_o
);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wrPtr_q;
  logic [AW-1:0]         rdPtr_q;
  logic [CW-1:0]         count_q;

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wrPtr_q] <= wdata_i;
    end
  end

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        wrPtr_q <= wrPtr_q + AW'(1);
      end
      if (pop_i) begin
        rdPtr_q <= rdPtr_q + AW'(1);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/rf_tx_packetizer.sv
// Buffers UART bytes and releases them as threshold- or timeout-triggered bursts,
// with sticky overflow reporting and a held-off AUX idle indication.
module rf_tx_packetizer
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 512,
  parameter int PKT_MAX      = 58,
  parameter int IDLE_TIMEOUT = 200000,
  parameter int AUX_HOLD     = 5000,
  localparam int CNT_W = cntWidth(FIFO_DEPTH)
) (
  input  logic                  internal_clk,
  input  logic                  rst_n,
  input  logic                  wr_valid,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [CNT_W-1:0]      thresh,
  output logic                  tx_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic                  aux,
  output logic [CNT_W-1:0]      count,
  output logic                  overflow,
  input  logic                  clr_overflow
);

  localparam int TMR_W  = cntWidth(IDLE_TIMEOUT);
  localparam int HOLD_W = cntWidth(AUX_HOLD);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  PKT_C     = CNT_W'(PKT_MAX);
  localparam logic [TMR_W-1:0]  TMO_LAST  = TMR_W'(IDLE_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(AUX_HOLD - 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    burstLen_q, burstLen_d;
  logic [CNT_W-1:0]    burstCnt_q, burstCnt_d;
  logic [TMR_W-1:0]    idleTmr_q, idleTmr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                aux_q, aux_d;
  logic                overflow_q, overflow_d;

  logic [DATA_WIDTH-1:0] fifoRdata;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic [CNT_W-1:0]      fifoCount;
  logic [CNT_W-1:0]      effThresh;
  logic [CNT_W-1:0]      cntNext;
  logic                  popEn;
  logic                  wrAccept;
  logic                  lastWord;
  logic                  busy;

  assign effThresh = ((thresh == '0) || (thresh > DEPTH_C)) ? PKT_C : thresh;
  assign popEn     = (state_q == SEND) && tx_ready && !fifoEmpty;
  assign wrAccept  = wr_valid && (!fifoFull || popEn);
  assign cntNext   = fifoCount + CNT_W'(wrAccept) - CNT_W'(popEn);
  assign lastWord  = (state_q == SEND) && (burstCnt_q == burstLen_q - CNT_W'(1));

  rf_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk_i   (internal_clk),
    .rst_ni  (rst_n),
    .push_i  (wrAccept),
    .wdata_i (wr_data),
    .pop_i   (popEn),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  always_ff @(posedge internal_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      burstLen_q <= '0;
      burstCnt_q <= '0;
      idleTmr_q  <= '0;
      hold_q     <= '0;
      aux_q      <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      burstLen_q <= burstLen_d;
      burstCnt_q <= burstCnt_d;
      idleTmr_q  <= idleTmr_d;
      hold_q     <= hold_d;
      aux_q      <= aux_d;
      overflow_q <= overflow_d;
    end
  end

  // The burst decision after the final pop looks at the post-pop occupancy,
  // including any write landing in the same cycle.
  always_comb begin
    state_d    = state_q;
    burstLen_d = burstLen_q;
    burstCnt_d = burstCnt_q;
    idleTmr_d  = idleTmr_q;
    case (state_q)
      IDLE: begin
        idleTmr_d  = '0;
        burstCnt_d = '0;
        if (wrAccept) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        idleTmr_d = wrAccept ? '0 : idleTmr_q + TMR_W'(1);
        if (fifoCount >= effThresh) begin
          state_d    = SEND;
          burstLen_d = effThresh;
          burstCnt_d = '0;
          idleTmr_d  = '0;
        end else if (idleTmr_q >= TMO_LAST) begin
          state_d    = (fifoCount != '0) ? SEND : IDLE;
          burstLen_d = fifoCount;
          burstCnt_d = '0;
          idleTmr_d  = '0;
        end
      end
      SEND: begin
        idleTmr_d = '0;
        if (popEn) begin
          if (lastWord) begin
            burstCnt_d = '0;
            if (cntNext >= effThresh) begin
              burstLen_d = effThresh;
            end else if (cntNext != '0) begin
              state_d = COLLECT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            burstCnt_d = burstCnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // AUX only rises after the block has sat idle and empty, with no write strobe, for the full hold.
  always_comb begin
    busy       = (state_q != IDLE) || (fifoCount != '0) || wr_valid;
    hold_d     = hold_q;
    aux_d      = 1'b0;
    overflow_d = overflow_q;
    if (busy) begin
      hold_d = '0;
    end else if (hold_q >= HOLD_LAST) begin
      aux_d = 1'b1;
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
    if (wr_valid && !wrAccept) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  assign tx_valid = (state_q == SEND);
  assign tx_data  = tx_valid ? fifoRdata : '0;
  assign tx_last  = lastWord;
  assign aux      = aux_q;
  assign count    = fifoCount;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_rf_tx_packetizer.sv
// Scoreboard bench for rf_tx_packetizer: expected words are queued as bytes are written
// and compared against every accepted output word.
module tb_rf_tx_packetizer;

  localparam int CW = 5;

  logic          clk;
  logic          rst_n;
  logic          wr_valid;
  logic [7:0]    wr_data;
  logic [CW-1:0] thresh;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_last;
  logic          tx_ready;
  logic          aux;
  logic [CW-1:0] count;
  logic          overflow;
  logic          clr_overflow;

  int            testsRun = 0;
  int            failCount = 0;
  logic [8:0]    expQ [$];
  logic          stallArm = 1'b0;
  logic [7:0]    stallData = '0;
  logic          stallLast = 1'b0;

  rf_tx_packetizer #(
    .DATA_WIDTH   (8),
    .FIFO_DEPTH   (16),
    .PKT_MAX      (4),
    .IDLE_TIMEOUT (20),
    .AUX_HOLD     (5)
  ) dut (
    .internal_clk (clk),
    .rst_n        (rst_n),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .thresh       (thresh),
    .tx_valid     (tx_valid),
    .tx_data      (tx_data),
    .tx_last      (tx_last),
    .tx_ready     (tx_ready),
    .aux          (aux),
    .count        (count),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drives one write strobe starting just after a rising edge; optionally queues the expected word.
  task automatic applyStimulus(input logic [7:0] data, input logic pushExp, input logic lastExp);
    wr_valid = 1'b1;
    wr_data  = data;
    if (pushExp) expQ.push_back({lastExp, data});
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic waitDrain(input int maxCycles);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!((count == '0) && !tx_valid) && (n < maxCycles));
    checkOutput("drainDone", 32'((count == '0) && !tx_valid), 32'd1);
  endtask

  task automatic checkAuxRise(input int lowCycles);
    for (int i = 0; i < lowCycles; i++) begin
      @(negedge clk);
      checkOutput("auxHeldLow", 32'(aux), 32'd0);
    end
    @(negedge clk);
    checkOutput("auxRise", 32'(aux), 32'd1);
  endtask

  // Output monitor: scoreboard pops on every transfer, and stalled outputs must not move.
  always @(negedge clk) begin
    logic [8:0] expWord;
    if (!rst_n) begin
      stallArm = 1'b0;
    end else begin
      if (stallArm) begin
        checkOutput("stallValid", 32'(tx_valid), 32'd1);
        checkOutput("stallData", 32'(tx_data), 32'(stallData));
        checkOutput("stallLast", 32'(tx_last), 32'(stallLast));
      end
      if (tx_valid && tx_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedWord", 32'(tx_data), 32'hFFFF_FFFF);
        end else begin
          expWord = expQ.pop_front();
          checkOutput("txData", 32'(tx_data), 32'(expWord[7:0]));
          checkOutput("txLast", 32'(tx_last), 32'(expWord[8]));
        end
      end
      stallArm  = tx_valid && !tx_ready;
      stallData = tx_data;
      stallLast = tx_last;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic seenValid;
    int   n;
    rst_n        = 1'b0;
    wr_valid     = 1'b0;
    wr_data      = '0;
    thresh       = '0;
    tx_ready     = 1'b0;
    clr_overflow = 1'b0;

    // Reset values, then AUX rises after the hold period.
    repeat (2) @(negedge clk);
    checkOutput("rstTxValid", 32'(tx_valid), 32'd0);
    checkOutput("rstTxLast", 32'(tx_last), 32'd0);
    checkOutput("rstTxData", 32'(tx_data), 32'd0);
    checkOutput("rstCount", 32'(count), 32'd0);
    checkOutput("rstOverflow", 32'(overflow), 32'd0);
    checkOutput("rstAux", 32'(aux), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checkAuxRise(5);
    @(negedge clk);
    checkOutput("postRstCount", 32'(count), 32'd0);
    checkOutput("postRstValid", 32'(tx_valid), 32'd0);

    // Threshold burst of four with the consumer always ready.
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    applyStimulus(8'h11, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("auxFallOnWrite", 32'(aux), 32'd0);
    checkOutput("countAfterWrite", 32'(count), 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(8'h22, 1'b1, 1'b0);
    applyStimulus(8'h33, 1'b1, 1'b0);
    applyStimulus(8'h44, 1'b1, 1'b1);
    waitDrain(40);
    checkAuxRise(4);

    // Partial buffer is flushed only after the idle timeout.
    @(posedge clk);
    #1;
    applyStimulus(8'h51, 1'b1, 1'b0);
    applyStimulus(8'h52, 1'b1, 1'b0);
    applyStimulus(8'h53, 1'b1, 1'b1);
    seenValid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx_valid) seenValid = 1'b1;
    end
    checkOutput("noEarlyFlush", 32'(seenValid), 32'd0);
    @(negedge clk);
    checkOutput("flushAtTimeout", 32'(tx_valid), 32'd1);
    waitDrain(20);
    checkAuxRise(4);

    // Overflow while stalled, clear, then four ordered bursts.
    @(posedge clk);
    #1;
    tx_ready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      applyStimulus(8'h60 + 8'(i), (i < 16), ((i % 4) == 3));
    end
    @(negedge clk);
    checkOutput("fullCount", 32'(count), 32'd16);
    checkOutput("overflowSet", 32'(overflow), 32'd1);
    @(posedge clk);
    #1;
    clr_overflow = 1'b1;
    @(posedge clk);
    #1;
    clr_overflow = 1'b0;
    @(negedge clk);
    checkOutput("overflowClr", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    tx_ready = 1'b1;
    waitDrain(80);
    checkAuxRise(4);

    // Runtime threshold of six with a toggling consumer, remainder flushed by timeout.
    @(posedge clk);
    #1;
    thresh   = 5'd6;
    tx_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          applyStimulus(8'h80 + 8'(i), 1'b1, (i == 5) || (i == 9));
        end
      end
      begin
        for (int i = 0; i < 24; i++) begin
          @(posedge clk);
          #1;
          tx_ready = ~tx_ready;
        end
      end
    join
    tx_ready = 1'b1;
    waitDrain(120);
    checkAuxRise(4);

    // Reset in the middle of a stalled burst.
    @(posedge clk);
    #1;
    thresh   = '0;
    tx_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'hC0 + 8'(i), 1'b0, 1'b0);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tx_valid && (n < 10));
    checkOutput("burstBeforeReset", 32'(tx_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRstValid", 32'(tx_valid), 32'd0);
    checkOutput("asyncRstLast", 32'(tx_last), 32'd0);
    checkOutput("asyncRstData", 32'(tx_data), 32'd0);
    checkOutput("asyncRstCount", 32'(count), 32'd0);
    checkOutput("asyncRstAux", 32'(aux), 32'd0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    tx_ready = 1'b1;
    rst_n    = 1'b1;
    checkAuxRise(5);
    seenValid = 1'b0;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      if (tx_valid || (count != '0)) seenValid = 1'b1;
    end
    checkOutput("noStaleData", 32'(seenValid), 32'd0);

    // Out-of-range threshold falls back to the default burst length.
    @(posedge clk);
    #1;
    thresh = 5'd20;
    applyStimulus(8'hA1, 1'b1, 1'b0);
    applyStimulus(8'hA2, 1'b1, 1'b0);
    applyStimulus(8'hA3, 1'b1, 1'b0);
    applyStimulus(8'hA4, 1'b1, 1'b1);
    seenValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (tx_valid) seenValid = 1'b1;
    end
    checkOutput("bigThreshFallback", 32'(seenValid), 32'd1);
    waitDrain(40);
    checkAuxRise(4);
    checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
